// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Frames a UART byte stream into checksummed command packets
//                (SYNC, CMD, LEN, payload, CHK) and presents each good packet
//                on a valid/ready handshake. Framing problems are reported as
//                one-cycle error pulses; stalled packets abort on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
   parameter int          MAX_LEN        = 8,
   parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
   parameter int          TIMEOUT_CYCLES = 1_250_000
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [7:0]             rx_data_i,
   input  logic                   rx_valid_i,
   output logic                   cmd_valid_o,
   input  logic                   cmd_ready_i,
   output logic [7:0]             cmd_code_o,
   output logic [7:0]             cmd_len_o,
   output logic [8*MAX_LEN-1:0]   cmd_payload_o,
   output logic                   err_chk_o,
   output logic                   err_len_o,
   output logic                   err_timeout_o,
   output logic                   err_overrun_o,
   output logic                   busy_o
);

   // Timer width; guarded so a degenerate TIMEOUT_CYCLES of 1 still yields a legal vector.
   localparam int             c_tw        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_tw-1:0] c_tmr_last = c_tw'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     c_max_len   = 8'(MAX_LEN);

   // Parser states
   localparam logic [2:0] c_st_hunt    = 3'd0;
   localparam logic [2:0] c_st_cmd     = 3'd1;
   localparam logic [2:0] c_st_len     = 3'd2;
   localparam logic [2:0] c_st_payload = 3'd3;
   localparam logic [2:0] c_st_chk     = 3'd4;
   localparam logic [2:0] c_st_done    = 3'd5;

   logic [2:0]             state_q,       state_d;
   logic [7:0]             code_q,        code_d;
   logic [7:0]             len_q,         len_d;
   logic [8*MAX_LEN-1:0]   payload_q,     payload_d;
   logic [7:0]             acc_q,         acc_d;
   logic [7:0]             idx_q,         idx_d;
   logic [c_tw-1:0]        tmr_q,         tmr_d;
   logic                   valid_q,       valid_d;
   logic                   busy_q,        busy_d;
   logic                   err_chk_q,     err_chk_d;
   logic                   err_len_q,     err_len_d;
   logic                   err_timeout_q, err_timeout_d;
   logic                   err_overrun_q, err_overrun_d;

   logic                   w_timed;
   logic                   w_expire;
   logic                   w_len_bad;
   logic                   w_last_payload;

   // Timeout only applies while a packet is being collected (CMD..CHK).
   assign w_timed        = (state_q == c_st_cmd) || (state_q == c_st_len) ||
                           (state_q == c_st_payload) || (state_q == c_st_chk);
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign w_expire       = w_timed && !rx_valid_i && (tmr_q == c_tmr_last);
   assign w_len_bad      = (rx_data_i > c_max_len);
   assign w_last_payload = ((idx_q + 8'd1) == len_q);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= c_st_hunt;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision: advance on received bytes, abort on timeout, leave DONE on handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_hunt: begin
            if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
               state_d = c_st_cmd;
            end
         end
         c_st_cmd: begin
            if (rx_valid_i) begin
               state_d = c_st_len;
            end else if (w_expire) begin
               state_d = c_st_hunt;
            end
         end
         c_st_len: begin
            if (rx_valid_i) begin
               if (w_len_bad) begin
                  state_d = c_st_hunt;
               end else if (rx_data_i == 8'd0) begin
                  state_d = c_st_chk;
               end else begin
                  state_d = c_st_payload;
               end
            end else if (w_expire) begin
               state_d = c_st_hunt;
            end
         end
         c_st_payload: begin
            if (rx_valid_i) begin
               if (w_last_payload) begin
                  state_d = c_st_chk;
               end
            end else if (w_expire) begin
               state_d = c_st_hunt;
            end
         end
         c_st_chk: begin
            if (rx_valid_i) begin
               state_d = (rx_data_i == acc_q) ? c_st_done : c_st_hunt;
            end else if (w_expire) begin
               state_d = c_st_hunt;
            end
         end
         c_st_done: begin
            // cmd_valid is high throughout DONE, so ready alone completes the handshake.
            if (cmd_ready_i) begin
               state_d = c_st_hunt;
            end
         end
         default: begin
            state_d = c_st_hunt;
         end
      endcase
   end

   // Datapath and output next values: capture fields, fold the checksum, raise error pulses.
   always_comb begin
      code_d        = code_q;
      len_d         = len_q;
      payload_d     = payload_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_overrun_d = 1'b0;
      err_timeout_d = w_expire;

      // Counter restarts on every accepted byte and whenever collection is not active,
      // so it is already zero on entry to CMD.
      if (w_timed && !rx_valid_i && !w_expire) begin
         tmr_d = tmr_q + {{(c_tw-1){1'b0}}, 1'b1};
      end else begin
         tmr_d = '0;
      end

      case (state_q)
         c_st_cmd: begin
            if (rx_valid_i) begin
               code_d = rx_data_i;
               acc_d  = rx_data_i;
            end
         end
         c_st_len: begin
            if (rx_valid_i) begin
               if (w_len_bad) begin
                  err_len_d = 1'b1;
               end else begin
                  len_d     = rx_data_i;
                  acc_d     = acc_q ^ rx_data_i;
                  payload_d = '0;
                  idx_d     = 8'd0;
               end
            end
         end
         c_st_payload: begin
            if (rx_valid_i) begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (idx_q == 8'(i)) begin
                     payload_d[8*i +: 8] = rx_data_i;
                  end
               end
               acc_d = acc_q ^ rx_data_i;
               idx_d = idx_q + 8'd1;
            end
         end
         c_st_chk: begin
            if (rx_valid_i && (rx_data_i != acc_q)) begin
               err_chk_d = 1'b1;
            end
         end
         c_st_done: begin
            // No room for another packet: the byte is dropped, even on the handshake cycle.
            if (rx_valid_i) begin
               err_overrun_d = 1'b1;
            end
         end
         default: begin
         end
      endcase

      valid_d = (state_d == c_st_done);
      busy_d  = (state_d != c_st_hunt);
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         code_q        <= '0;
         len_q         <= '0;
         payload_q     <= '0;
         acc_q         <= '0;
         idx_q         <= '0;
         tmr_q         <= '0;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         code_q        <= code_d;
         len_q         <= len_d;
         payload_q     <= payload_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         tmr_q         <= tmr_d;
         valid_q       <= valid_d;
         busy_q        <= busy_d;
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign cmd_valid_o   = valid_q;
   assign cmd_code_o    = code_q;
   assign cmd_len_o     = len_q;
   assign cmd_payload_o = payload_q;
   assign err_chk_o     = err_chk_q;
   assign err_len_o     = err_len_q;
   assign err_timeout_o = err_timeout_q;
   assign err_overrun_o = err_overrun_q;
   assign busy_o        = busy_q;

endmodule
`default_nettype wire
